mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, RV32M funct3 encodings and the
// multiply/divide sequencer state type.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on a shared
// 64-bit register, fixed 34-cycle start-to-done latency for every operation.
module mul_div_unit #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  localparam int unsigned DW = 2 * XLEN;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q;
  logic              sign_a_q, sign_b_q, div_zero_q, ovf_q;
  logic [DW-1:0]     acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q, busy_d, done_d;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [DW-1:0]     mul_next, div_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic [DW-1:0]     prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  // Operand signedness and magnitudes captured at acceptance
  always_comb begin
    s1   = rs1[XLEN-1] && ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                           (funct3 == F3_DIV)  || (funct3 == F3_REM));
    s2   = rs2[XLEN-1] && ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                           (funct3 == F3_REM));
    mag1 = s1 ? (XLEN'(0) - rs1) : rs1;
    mag2 = s2 ? (XLEN'(0) - rs2) : rs2;
  end

  // Multiply: add multiplicand into the upper half when the low bit is set, shift right.
  // Divide: shift remainder:quotient left, subtract divisor when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, (acc_q[0] ? a_mag_q : XLEN'(0))};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[DW-1:XLEN-1];
    rem_sub  = rem_sh[XLEN-1:0] - b_mag_q;
    if (rem_sh >= {1'b0, b_mag_q}) begin
      div_next = {rem_sub, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction, special cases and field selection applied in FIX
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (DW'(0) - acc_q) : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? (XLEN'(0) - acc_q[DW-1:XLEN]) : acc_q[DW-1:XLEN];
    if (div_zero_q) begin
      quot_fix = '1;
      rem_fix  = sign_a_q ? (XLEN'(0) - a_mag_q) : a_mag_q;
    end else if (ovf_q) begin
      quot_fix = {1'b1, (XLEN-1)'(0)};
      rem_fix  = '0;
    end
    case (op_q)
      F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[DW-1:XLEN];
      F3_DIV, F3_DIVU:              fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_CALC : S_IDLE;
      S_CALC:         if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from the upcoming state
  always_comb begin
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        op_q       <= funct3;
        a_mag_q    <= mag1;
        b_mag_q    <= mag2;
        sign_a_q   <= s1;
        sign_b_q   <= s2;
        div_zero_q <= funct3[2] && (rs2 == '0);
        ovf_q      <= ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1 == {1'b1, (XLEN-1)'(0)}) && (rs2 == '1);
        acc_q      <= {XLEN'(0), (funct3[2] ? mag1 : mag2)};
        cnt_q      <= '0;
      end else if (state_q == S_CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == S_FIX) begin
        result_q <= fix_result;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
